// File: rtl/dataset_buffer.sv
// Row store for deserialized dataset rows: captures rows into memory, keeps
// per-lane running sums, and serves a 1-cycle random read port.
module dataset_buffer #(
  parameter int MAX_FEATURES = 6,
  parameter int LANE_W       = 16,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int SUM_W        = LANE_W + ADDR_WIDTH,
  parameter int ROW_W        = 192
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 start,
  input  logic [11:0]                          num_dp,
  input  logic [3:0]                           feat,
  input  logic                                 row_valid,
  input  logic [ROW_W-1:0]                     row_data,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [(MAX_FEATURES+1)*LANE_W-1:0]   rd_data,
  output logic                                 rd_valid,
  output logic [(MAX_FEATURES+1)*SUM_W-1:0]    sums,
  output logic [ADDR_WIDTH:0]                  row_count,
  output logic                                 ready,
  output logic                                 cfg_err,
  output logic                                 ovf
);

  localparam int LANES = MAX_FEATURES + 1;
  localparam int MEM_W = LANES * LANE_W;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [ADDR_WIDTH:0]    num_r;
  logic [3:0]             feat_r;
  logic [ADDR_WIDTH:0]    row_count_r;
  logic [SUM_W-1:0]       sum_r [LANES];
  logic                   ready_r, cfg_err_r, ovf_r, rd_valid_r;
  logic [MEM_W-1:0]       rd_data_r;
  logic [MEM_W-1:0]       mem [DEPTH];
  logic [MEM_W-1:0]       wr_row_s;
  logic                   begin_s, accept_s, drop_s, cfg_bad_s, last_s;
  logic                   row_unused_s;

  function automatic logic [SUM_W-1:0] sext(input logic [LANE_W-1:0] v);
    return {{(SUM_W-LANE_W){v[LANE_W-1]}}, v};
  endfunction

  assign cfg_bad_s    = (num_dp == 12'd0) || (num_dp > 12'(DEPTH)) ||
                        (feat > 4'(MAX_FEATURES));
  assign last_s       = ((row_count_r + CNT_ONE) == num_r);
  assign row_unused_s = ^row_data[ROW_W-1:MEM_W];

  // Zero lanes above the active feature count before storing/summing.
  always_comb begin
    wr_row_s = '0;
    for (int k = 0; k < LANES; k++) begin
      if (4'(k) <= feat_r) begin
        wr_row_s[k*LANE_W +: LANE_W] = row_data[k*LANE_W +: LANE_W];
      end else begin
        wr_row_s[k*LANE_W +: LANE_W] = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    begin_s     = 1'b0;
    accept_s    = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      IDLE, READY: begin
        if (start) begin
          begin_s     = 1'b1;
          state_nxt_s = cfg_bad_s ? READY : LOAD;
        end else begin
          state_nxt_s = state_r;
        end
        if (row_valid) begin
          drop_s = 1'b1;
        end else begin
          drop_s = 1'b0;
        end
      end
      LOAD: begin
        if (row_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = last_s ? READY : LOAD;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Configuration, counters, sums and status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      num_r       <= '0;
      feat_r      <= 4'd0;
      row_count_r <= '0;
      ready_r     <= 1'b0;
      cfg_err_r   <= 1'b0;
      ovf_r       <= 1'b0;
      for (int k = 0; k < LANES; k++) sum_r[k] <= '0;
    end else begin
      if (begin_s) begin
        num_r       <= num_dp[ADDR_WIDTH:0];
        feat_r      <= feat;
        row_count_r <= '0;
        cfg_err_r   <= cfg_bad_s;
        ready_r     <= cfg_bad_s;
        for (int k = 0; k < LANES; k++) sum_r[k] <= '0;
      end else if (accept_s) begin
        row_count_r <= row_count_r + CNT_ONE;
        if (last_s) ready_r <= 1'b1;
        for (int k = 0; k < LANES; k++) begin
          sum_r[k] <= sum_r[k] + sext(wr_row_s[k*LANE_W +: LANE_W]);
        end
      end
      // A dropped row sets ovf even when start clears it in the same cycle.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (begin_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Row memory write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      mem[row_count_r[ADDR_WIDTH-1:0]] <= wr_row_s;
    end
  end

  // Registered read port, read-before-write against the write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) rd_data_r <= mem[rd_addr];
    end
  end

  // Pack lane sums onto the output bus.
  always_comb begin
    sums = '0;
    for (int k = 0; k < LANES; k++) begin
      sums[k*SUM_W +: SUM_W] = sum_r[k];
    end
  end

  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign row_count = row_count_r;
  assign ready     = ready_r;
  assign cfg_err   = cfg_err_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_dataset_buffer.sv
// Directed testbench for dataset_buffer: load, readback, config errors,
// overflow, mid-load reset, read-before-write and full-depth sums.
module tb_dataset_buffer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [11:0]  num_dp;
  logic [3:0]   feat;
  logic         row_valid;
  logic [191:0] row_data;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [111:0] rd_data;
  logic         rd_valid;
  logic [153:0] sums;
  logic [6:0]   row_count;
  logic         ready;
  logic         cfg_err;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  dataset_buffer dut (
    .CLK(CLK), .RST(RST), .start(start), .num_dp(num_dp), .feat(feat),
    .row_valid(row_valid), .row_data(row_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .sums(sums), .row_count(row_count),
    .ready(ready), .cfg_err(cfg_err), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] mkrow(input int l0, l1, l2, l3, l4, l5, l6);
    logic [191:0] r;
    r = '0;
    r[15:0]   = 16'(l0);
    r[31:16]  = 16'(l1);
    r[47:32]  = 16'(l2);
    r[63:48]  = 16'(l3);
    r[79:64]  = 16'(l4);
    r[95:80]  = 16'(l5);
    r[111:96] = 16'(l6);
    return r;
  endfunction

  function automatic logic [153:0] mksum(input int s0, s1, s2, s3, s4, s5, s6);
    logic [153:0] r;
    r = '0;
    r[21:0]    = 22'(s0);
    r[43:22]   = 22'(s1);
    r[65:44]   = 22'(s2);
    r[87:66]   = 22'(s3);
    r[109:88]  = 22'(s4);
    r[131:110] = 22'(s5);
    r[153:132] = 22'(s6);
    return r;
  endfunction

  initial begin
    RST = 1'b1; start = 1'b0; num_dp = 12'd0; feat = 4'd0;
    row_valid = 1'b0; row_data = '0; rd_en = 1'b0; rd_addr = 6'd0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_ready", 256'(ready), 256'(0));
    chk("rst_count", 256'(row_count), 256'(0));
    chk("rst_sums", 256'(sums), 256'(0));
    chk("rst_flags", 256'({rd_valid, cfg_err, ovf}), 256'(0));
    chk("rst_rd_data", 256'(rd_data), 256'(0));

    // Normal load, lanes above feat carry junk that must be masked
    start = 1'b1; num_dp = 12'd3; feat = 4'd2; tick(); start = 1'b0;
    row_valid = 1'b1;
    row_data = mkrow(1, 2, 3, 9, 9, 9, 9); tick();
    row_data = mkrow(4, 5, 6, 7, 7, 7, 7); tick();
    chk("load2_count", 256'(row_count), 256'(2));
    chk("load2_ready", 256'(ready), 256'(0));
    row_data = mkrow(-1, -1, -1, 5, 5, 5, 5); tick();
    row_valid = 1'b0;
    chk("load_ready", 256'(ready), 256'(1));
    chk("load_count", 256'(row_count), 256'(3));
    chk("load_sums", 256'(sums), 256'(mksum(4, 6, 8, 0, 0, 0, 0)));

    // Readback
    rd_en = 1'b1; rd_addr = 6'd1; tick(); rd_en = 1'b0;
    chk("rd1_data", 256'(rd_data), 256'(mkrow(4, 5, 6, 0, 0, 0, 0)));
    chk("rd1_valid", 256'(rd_valid), 256'(1));
    tick();
    chk("rd_idle_valid", 256'(rd_valid), 256'(0));
    chk("rd_idle_hold", 256'(rd_data), 256'(mkrow(4, 5, 6, 0, 0, 0, 0)));

    // Overflow: extra row after ready, read row 0
    row_valid = 1'b1; row_data = mkrow(100, 100, 100, 100, 100, 100, 100);
    rd_en = 1'b1; rd_addr = 6'd0; tick();
    row_valid = 1'b0; rd_en = 1'b0;
    chk("ovf_flag", 256'(ovf), 256'(1));
    chk("ovf_sums", 256'(sums), 256'(mksum(4, 6, 8, 0, 0, 0, 0)));
    chk("ovf_count", 256'(row_count), 256'(3));
    chk("ovf_row0", 256'(rd_data), 256'(mkrow(1, 2, 3, 0, 0, 0, 0)));

    // Config errors
    start = 1'b1; num_dp = 12'd3; feat = 4'd7; tick(); start = 1'b0;
    chk("cfg_feat", 256'({cfg_err, ready, ovf}), 256'(3'b110));
    chk("cfg_feat_count", 256'(row_count), 256'(0));
    chk("cfg_feat_sums", 256'(sums), 256'(0));
    start = 1'b1; num_dp = 12'd0; feat = 4'd2; tick(); start = 1'b0;
    chk("cfg_zero", 256'({cfg_err, ready, row_count}), 256'({2'b11, 7'd0}));
    start = 1'b1; num_dp = 12'd65; feat = 4'd2; tick(); start = 1'b0;
    chk("cfg_depth", 256'({cfg_err, ready}), 256'(2'b11));

    // Legal start clears cfg_err; reset after 2 of 5 rows
    start = 1'b1; num_dp = 12'd5; feat = 4'd1; tick(); start = 1'b0;
    chk("cfg_clear", 256'({cfg_err, ready}), 256'(2'b00));
    row_valid = 1'b1;
    row_data = mkrow(10, 20, 0, 0, 0, 0, 0); tick();
    row_data = mkrow(30, 40, 0, 0, 0, 0, 0); tick();
    row_valid = 1'b0;
    chk("mid_sums", 256'(sums), 256'(mksum(40, 60, 0, 0, 0, 0, 0)));
    start = 1'b1; num_dp = 12'd1; feat = 4'd7; tick(); start = 1'b0;
    chk("start_in_load", 256'({cfg_err, row_count}), 256'({1'b0, 7'd2}));
    RST = 1'b1; tick(); RST = 1'b0;
    chk("mid_rst", 256'({ready, row_count}), 256'(0));
    chk("mid_rst_sums", 256'(sums), 256'(0));

    // Restart from IDLE with simultaneous start and row_valid
    start = 1'b1; num_dp = 12'd5; feat = 4'd1;
    row_valid = 1'b1; row_data = mkrow(77, 77, 0, 0, 0, 0, 0); tick();
    start = 1'b0;
    chk("start_drop", 256'({ovf, ready, row_count}), 256'({2'b10, 7'd0}));
    chk("start_drop_sums", 256'(sums), 256'(0));
    row_data = mkrow(1, -2, 0, 0, 0, 0, 0);
    rd_en = 1'b1; rd_addr = 6'd0; tick(); rd_en = 1'b0;
    chk("rbw_old", 256'(rd_data), 256'(mkrow(10, 20, 0, 0, 0, 0, 0)));
    for (int i = 2; i <= 4; i++) begin
      row_data = mkrow(i, -2 * i, 0, 0, 0, 0, 0); tick();
    end
    chk("restart4_ready", 256'(ready), 256'(0));
    row_data = mkrow(5, -10, 0, 0, 0, 0, 0); tick();
    row_valid = 1'b0;
    chk("restart_done", 256'({ready, row_count}), 256'({1'b1, 7'd5}));
    chk("restart_sums", 256'(sums), 256'(mksum(15, -30, 0, 0, 0, 0, 0)));
    rd_en = 1'b1; rd_addr = 6'd0; tick(); rd_en = 1'b0;
    chk("rbw_new", 256'(rd_data), 256'(mkrow(1, -2, 0, 0, 0, 0, 0)));

    // Full depth with maximum positive lanes
    start = 1'b1; num_dp = 12'd64; feat = 4'd6; tick(); start = 1'b0;
    row_valid = 1'b1;
    row_data = mkrow(32767, 32767, 32767, 32767, 32767, 32767, 32767);
    for (int i = 0; i < 63; i++) tick();
    chk("full63_ready", 256'({ready, row_count}), 256'({1'b0, 7'd63}));
    tick();
    row_valid = 1'b0;
    chk("full_done", 256'({ready, cfg_err, row_count}), 256'({2'b10, 7'd64}));
    chk("full_sums", 256'(sums), 256'(mksum(2097088, 2097088, 2097088, 2097088,
                                            2097088, 2097088, 2097088)));
    rd_en = 1'b1; rd_addr = 6'd63; tick(); rd_en = 1'b0;
    chk("full_row63", 256'(rd_data),
        256'(mkrow(32767, 32767, 32767, 32767, 32767, 32767, 32767)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
